// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared state encodings and defaults for the fetch sequencer
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_STALL = 2'b10,
    ST_HALT  = 2'b11
  } fetch_state_e;

  localparam int unsigned DEFAULT_RESET_ADDR  = 0;
  localparam int unsigned DEFAULT_STACK_DEPTH = 4;

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - return-address LIFO; pushes when full and pops when empty are dropped
module ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [2**IW];
  logic [CW-1:0]    count_q;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    top_idx;

  assign wr_idx  = count_q[IW-1:0];
  assign top_idx = wr_idx - IW'(1);
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign top     = mem_q[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (push && !full) begin
      count_q <= count_q + CW'(1);
    end else if (pop && !empty) begin
      count_q <= count_q - CW'(1);
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch PC sequencer with branch, call/return and stall handling
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned RESET_ADDR  = DEFAULT_RESET_ADDR,
  parameter int unsigned STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  call_en,
  input  logic [ADDR_WIDTH-1:0] call_target,
  input  logic                  ret_en,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [1:0]            state_out,
  output logic                  stack_err
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  stk_push, stk_pop, stk_full, stk_empty;
  logic [ADDR_WIDTH-1:0] stk_top;

  assign pc_inc      = pc_q + ADDR_WIDTH'(1);
  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign state_out   = state_q;
  assign stack_err   = err_q;
  assign instr_valid = imem_req & imem_ack & ~stall & ~branch_taken
                     & ~call_en & ~ret_en & ~halt;

  ret_stack #(
    .DEPTH(STACK_DEPTH),
    .WIDTH(ADDR_WIDTH)
  ) u_ret_stack (
    .clk      (clk),
    .rst_n    (reset),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_data(pc_inc),
    .top      (stk_top),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
        if (halt) begin
          state_d = ST_HALT;
        end else if (ret_en) begin
          // An empty-stack return falls through to the next sequential address.
          if (stk_empty) begin
            err_d = 1'b1;
            pc_d  = pc_inc;
          end else begin
            stk_pop = 1'b1;
            pc_d    = stk_top;
          end
        end else if (call_en) begin
          pc_d = call_target;
          if (stk_full) err_d = 1'b1;
          else          stk_push = 1'b1;
        end else if (branch_taken) begin
          pc_d = branch_target;
        end else if (stall) begin
          state_d = ST_STALL;
        end else if (state_q == ST_FETCH && imem_ack) begin
          pc_d = pc_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= ADDR_WIDTH'(RESET_ADDR);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, halt, stall, branch_taken, call_en, ret_en, imem_ack;
  logic [11:0] branch_target, call_target;
  logic        imem_req, instr_valid, stack_err;
  logic [11:0] imem_addr, pc_out;
  logic [1:0]  state_out;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .call_en(call_en), .call_target(call_target), .ret_en(ret_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .instr_valid(instr_valid), .pc_out(pc_out), .state_out(state_out),
    .stack_err(stack_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; halt = 0; stall = 0; branch_taken = 0; call_en = 0; ret_en = 0;
    imem_ack = 0; branch_target = '0; call_target = '0;
  endtask

  task automatic jump_to(input logic [11:0] addr);
    branch_taken = 1; branch_target = addr;
    step();
    branch_taken = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    clear_inputs();
    #3;
    checks++; if (state_out !== 2'b00) begin failures++; $display("FAIL reset_state got=%0h exp=0", state_out); end
    checks++; if (pc_out !== 12'h000) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc_out); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", stack_err); end
    reset = 1;
    step();
    checks++; if (state_out !== 2'b00) begin failures++; $display("FAIL idle_hold got=%0h exp=0", state_out); end
  endtask

  task automatic test_sequential_fetch();
    start = 1;
    step();
    start = 0;
    checks++; if (state_out !== 2'b01) begin failures++; $display("FAIL start_fetch got=%0h exp=1", state_out); end
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1;
      #1;
      checks++; if (imem_addr !== 12'(i)) begin failures++; $display("FAIL seq_addr%0d got=%0h exp=%0h", i, imem_addr, i); end
      checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b1) begin failures++; $display("FAIL seq_valid%0d req=%0b valid=%0b exp=1", i, imem_req, instr_valid); end
      step();
    end
    imem_ack = 0;
    checks++; if (pc_out !== 12'h003) begin failures++; $display("FAIL seq_pc got=%0h exp=3", pc_out); end
  endtask

  task automatic test_wrap();
    jump_to(12'hFFF);
    checks++; if (pc_out !== 12'hFFF) begin failures++; $display("FAIL wrap_setup got=%0h exp=fff", pc_out); end
    imem_ack = 1;
    step();
    imem_ack = 0;
    checks++; if (pc_out !== 12'h000) begin failures++; $display("FAIL wrap_pc got=%0h exp=0", pc_out); end
    checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL wrap_err got=%0b exp=0", stack_err); end
  endtask

  task automatic test_call_ret();
    jump_to(12'h010);
    call_en = 1; call_target = 12'h200; imem_ack = 1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL call_drop got=%0b exp=0", instr_valid); end
    step();
    call_en = 0;
    checks++; if (pc_out !== 12'h200) begin failures++; $display("FAIL call_pc got=%0h exp=200", pc_out); end
    step();
    imem_ack = 0;
    checks++; if (pc_out !== 12'h201) begin failures++; $display("FAIL call_seq got=%0h exp=201", pc_out); end
    ret_en = 1;
    step();
    ret_en = 0;
    checks++; if (pc_out !== 12'h011) begin failures++; $display("FAIL ret_pc got=%0h exp=11", pc_out); end
    checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL ret_err got=%0b exp=0", stack_err); end
  endtask

  task automatic test_stack_overflow();
    logic [11:0] pushed [4];
    logic [11:0] pc_before;
    jump_to(12'h100);
    for (int i = 0; i < 5; i++) begin
      pc_before = (i == 0) ? 12'h100 : 12'(12'h200 + 12'h100 * i);
      if (i < 4) pushed[i] = pc_before + 12'h001;
      call_en = 1; call_target = 12'(12'h300 + 12'h100 * i);
      step();
      call_en = 0;
      checks++; if (pc_out !== 12'(12'h300 + 12'h100 * i)) begin failures++; $display("FAIL ovf_call%0d got=%0h exp=%0h", i, pc_out, 12'h300 + 12'h100 * i); end
      if (i == 3) begin
        checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL ovf_full_err got=%0b exp=0", stack_err); end
      end
    end
    checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL ovf_err got=%0b exp=1", stack_err); end
    for (int k = 0; k < 4; k++) begin
      ret_en = 1;
      step();
      ret_en = 0;
      checks++; if (pc_out !== pushed[3-k]) begin failures++; $display("FAIL ovf_ret%0d got=%0h exp=%0h", k, pc_out, pushed[3-k]); end
    end
    ret_en = 1;
    step();
    ret_en = 0;
    checks++; if (pc_out !== 12'h102) begin failures++; $display("FAIL underflow_pc got=%0h exp=102", pc_out); end
    checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL underflow_err got=%0b exp=1", stack_err); end
  endtask

  task automatic test_stall_branch();
    jump_to(12'h005);
    stall = 1; imem_ack = 1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stall_valid got=%0b exp=0", instr_valid); end
    step();
    checks++; if (state_out !== 2'b10 || imem_req !== 1'b0) begin failures++; $display("FAIL stall_state state=%0h req=%0b exp=2/0", state_out, imem_req); end
    checks++; if (pc_out !== 12'h005) begin failures++; $display("FAIL stall_pc got=%0h exp=5", pc_out); end
    stall = 0; imem_ack = 0;
    step();
    checks++; if (state_out !== 2'b01 || pc_out !== 12'h005) begin failures++; $display("FAIL unstall state=%0h pc=%0h exp=1/5", state_out, pc_out); end
    branch_taken = 1; branch_target = 12'h0A0; imem_ack = 1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL branch_drop got=%0b exp=0", instr_valid); end
    step();
    branch_taken = 0; imem_ack = 0;
    checks++; if (pc_out !== 12'h0A0) begin failures++; $display("FAIL branch_pc got=%0h exp=a0", pc_out); end
  endtask

  task automatic test_async_reset_halt();
    imem_ack = 1;
    step();
    reset = 0;
    #1;
    checks++; if (state_out !== 2'b00 || pc_out !== 12'h000) begin failures++; $display("FAIL async_rst state=%0h pc=%0h exp=0/0", state_out, pc_out); end
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL async_rst_out req=%0b valid=%0b exp=0/0", imem_req, instr_valid); end
    checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL async_rst_err got=%0b exp=0", stack_err); end
    imem_ack = 0; reset = 1; start = 1;
    step();
    start = 0; imem_ack = 1;
    step();
    imem_ack = 0; halt = 1;
    step();
    halt = 0;
    checks++; if (state_out !== 2'b11 || pc_out !== 12'h001 || imem_req !== 1'b0) begin failures++; $display("FAIL halt state=%0h pc=%0h req=%0b exp=3/1/0", state_out, pc_out, imem_req); end
    branch_taken = 1; branch_target = 12'h777; imem_ack = 1;
    step();
    checks++; if (state_out !== 2'b11 || pc_out !== 12'h001) begin failures++; $display("FAIL halt_ignore state=%0h pc=%0h exp=3/1", state_out, pc_out); end
    start = 1;
    step();
    clear_inputs();
    checks++; if (state_out !== 2'b01 || pc_out !== 12'h001) begin failures++; $display("FAIL resume state=%0h pc=%0h exp=1/1", state_out, pc_out); end
  endtask

  initial begin
    test_reset();
    test_sequential_fetch();
    test_wrap();
    test_call_ret();
    test_stack_overflow();
    test_stall_branch();
    test_async_reset_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
